// File: rtl/alu_calc_core_if.sv
// ---------------------------------------------------------------------------
// alu_calc_core_if
// Bundles the board-side signals of alu_calc_core: switch/key inputs towards
// the core, and register, flag and BCD outputs towards the seven-segment
// decoders.
//
// Signals:
//   sw_data     operand value to load (WIDTH bits)
//   sw_sel_b    load target: 0 = A, 1 = B
//   sw_op       ALU operation code (3 bits)
//   key_load_n  load key, active-low, asynchronous
//   key_exec_n  execute key, active-low, asynchronous
//   reg_a/b/c   register contents (WIDTH bits)
//   ovr         overflow flag of the last execute
//   bcd_a/b/c   packed BCD of A, B, C (4*DIGITS bits, digit 0 in [3:0])
//   bcd_valid   one-cycle pulse when the BCD outputs update
//   busy        BCD conversion in progress
//
// Modports:
//   master  board / testbench side (drives switches and keys)
//   slave   alu_calc_core side (drives registers and BCD)
// ---------------------------------------------------------------------------
interface alu_calc_core_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);

  logic [WIDTH-1:0]    sw_data;
  logic                sw_sel_b;
  logic [2:0]          sw_op;
  logic                key_load_n;
  logic                key_exec_n;

  logic [WIDTH-1:0]    reg_a;
  logic [WIDTH-1:0]    reg_b;
  logic [WIDTH-1:0]    reg_c;
  logic                ovr;
  logic [4*DIGITS-1:0] bcd_a;
  logic [4*DIGITS-1:0] bcd_b;
  logic [4*DIGITS-1:0] bcd_c;
  logic                bcd_valid;
  logic                busy;

  modport master (
    output sw_data, sw_sel_b, sw_op, key_load_n, key_exec_n,
    input  reg_a, reg_b, reg_c, ovr, bcd_a, bcd_b, bcd_c, bcd_valid, busy
  );

  modport slave (
    input  sw_data, sw_sel_b, sw_op, key_load_n, key_exec_n,
    output reg_a, reg_b, reg_c, ovr, bcd_a, bcd_b, bcd_c, bcd_valid, busy
  );

endinterface

// File: rtl/alu_calc_core.sv
// ---------------------------------------------------------------------------
// alu_calc_core
// Operand registers A/B and result register C driven by two debounced
// push-keys. The load key writes sw_data into A or B, the execute key runs
// the ALU operation selected by sw_op into C and sets ovr. After every
// register write a serial double-dabble engine re-encodes A, B and C to
// packed BCD over WIDTH+2 cycles.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    alu_calc_core_if.slave (switches, keys, registers, BCD, status)
//
// Parameters:
//   WIDTH     operand/result width in bits (>= 2)
//   DIGITS    BCD digits per value, 10^DIGITS must exceed 2^WIDTH-1
//   DEBOUNCE  cycles a synchronised key level must be stable to be accepted
// ---------------------------------------------------------------------------
module alu_calc_core #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int DEBOUNCE = 250000
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_calc_core_if.slave   bus
);

  localparam int BW  = 4 * DIGITS;
  localparam int CW  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int SCW = $clog2(WIDTH);

  localparam logic [CW-1:0]  CNT_LAST   = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0]  CNT_ONE    = CW'(1);
  localparam logic [SCW-1:0] SHIFT_LAST = SCW'(WIDTH - 1);
  localparam logic [SCW-1:0] SHIFT_ONE  = SCW'(1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_ACC = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } conv_state_e;

  // Key path; index 0 is the load key, index 1 the execute key.
  logic [1:0]          sync1;
  logic [1:0]          sync2;
  logic [1:0]          deb_lvl;
  logic [1:0][CW-1:0]  deb_cnt;
  logic [1:0]          press;

  logic [WIDTH-1:0]    reg_a;
  logic [WIDTH-1:0]    reg_b;
  logic [WIDTH-1:0]    reg_c;
  logic                ovr;

  logic [WIDTH:0]      sum_ab;
  logic [WIDTH:0]      diff_ab;
  logic [WIDTH:0]      sum_ca;
  logic [WIDTH-1:0]    alu_c;
  logic                alu_ovr;

  logic                load_wr;
  logic                exec_wr;
  logic                wr_pend;

  conv_state_e         state;
  conv_state_e         state_nxt;
  logic                busy_i;
  logic                do_load;
  logic                do_shift;
  logic                do_done;

  logic [SCW-1:0]      shift_cnt;
  logic [WIDTH-1:0]    bin_a;
  logic [WIDTH-1:0]    bin_b;
  logic [WIDTH-1:0]    bin_c;
  logic [BW-1:0]       scr_a;
  logic [BW-1:0]       scr_b;
  logic [BW-1:0]       scr_c;
  logic [BW-1:0]       bcd_a;
  logic [BW-1:0]       bcd_b;
  logic [BW-1:0]       bcd_c;
  logic                bcd_valid;

  // One double-dabble step: correct every digit that would overflow past 9
  // on doubling, then shift the next binary bit in at the bottom.
  function automatic logic [BW-1:0] dabble(input logic [BW-1:0] bcd,
                                           input logic          bin_msb);
    logic [BW-1:0] t;
    t = bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (t[4*d +: 4] >= 4'd5) begin
        t[4*d +: 4] = t[4*d +: 4] + 4'd3;
      end
    end
    return {t[BW-2:0], bin_msb};
  endfunction

  // Two-flop synchroniser plus debounce per key. The counter runs only while
  // the synchronised level differs from the accepted level, so any return to
  // the accepted level restarts it. A press event is emitted on the edge the
  // accepted level falls from released to pressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      deb_lvl <= 2'b11;
      deb_cnt <= '0;
      press   <= 2'b00;
    end else begin
      sync1 <= {bus.key_exec_n, bus.key_load_n};
      sync2 <= sync1;
      for (int k = 0; k < 2; k++) begin
        press[k] <= 1'b0;
        if (sync2[k] == deb_lvl[k]) begin
          deb_cnt[k] <= '0;
        end else if (deb_cnt[k] == CNT_LAST) begin
          deb_cnt[k] <= '0;
          deb_lvl[k] <= sync2[k];
          press[k]   <= deb_lvl[k];
        end else begin
          deb_cnt[k] <= deb_cnt[k] + CNT_ONE;
        end
      end
    end
  end

  // Presses during a conversion are discarded; a simultaneous load beats
  // an execute.
  assign load_wr = press[0] & ~busy_i;
  assign exec_wr = press[1] & ~press[0] & ~busy_i;

  // Unsigned ALU on the current register contents; carry/borrow comes from
  // the extra top bit of the widened sums.
  always_comb begin
    sum_ab  = {1'b0, reg_a} + {1'b0, reg_b};
    diff_ab = {1'b0, reg_a} - {1'b0, reg_b};
    sum_ca  = {1'b0, reg_c} + {1'b0, reg_a};
    alu_c   = '0;
    alu_ovr = 1'b0;
    case (bus.sw_op)
      OP_ADD: begin
        alu_c   = sum_ab[WIDTH-1:0];
        alu_ovr = sum_ab[WIDTH];
      end
      OP_SUB: begin
        alu_c   = diff_ab[WIDTH-1:0];
        alu_ovr = diff_ab[WIDTH];
      end
      OP_AND: alu_c = reg_a & reg_b;
      OP_OR:  alu_c = reg_a | reg_b;
      OP_XOR: alu_c = reg_a ^ reg_b;
      OP_NOT: alu_c = ~reg_a;
      OP_SHL: begin
        alu_c   = {reg_a[WIDTH-2:0], 1'b0};
        alu_ovr = reg_a[WIDTH-1];
      end
      OP_ACC: begin
        alu_c   = sum_ca[WIDTH-1:0];
        alu_ovr = sum_ca[WIDTH];
      end
      default: begin
      end
    endcase
  end

  // Operand and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_a <= '0;
      reg_b <= '0;
      reg_c <= '0;
      ovr   <= 1'b0;
    end else if (load_wr) begin
      if (bus.sw_sel_b) begin
        reg_b <= bus.sw_data;
      end else begin
        reg_a <= bus.sw_data;
      end
    end else if (exec_wr) begin
      reg_c <= alu_c;
      ovr   <= alu_ovr;
    end
  end

  // Remembers a register write until the conversion FSM picks it up, which
  // places the rise of busy one edge after the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pend <= 1'b0;
    end else if (load_wr || exec_wr) begin
      wr_pend <= 1'b1;
    end else if (state == IDLE) begin
      wr_pend <= 1'b0;
    end
  end

  // Conversion FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Conversion FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (wr_pend) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (shift_cnt == SHIFT_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Conversion FSM outputs.
  always_comb begin
    busy_i   = (state != IDLE);
    do_load  = (state == LOAD);
    do_shift = (state == SHIFT);
    do_done  = (state == DONE);
  end

  // Three double-dabble engines running in lock-step; outputs are only
  // replaced together when a conversion completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_cnt <= '0;
      bin_a     <= '0;
      bin_b     <= '0;
      bin_c     <= '0;
      scr_a     <= '0;
      scr_b     <= '0;
      scr_c     <= '0;
      bcd_a     <= '0;
      bcd_b     <= '0;
      bcd_c     <= '0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= do_done;
      if (do_load) begin
        shift_cnt <= '0;
        bin_a     <= reg_a;
        bin_b     <= reg_b;
        bin_c     <= reg_c;
        scr_a     <= '0;
        scr_b     <= '0;
        scr_c     <= '0;
      end
      if (do_shift) begin
        shift_cnt <= shift_cnt + SHIFT_ONE;
        scr_a     <= dabble(scr_a, bin_a[WIDTH-1]);
        scr_b     <= dabble(scr_b, bin_b[WIDTH-1]);
        scr_c     <= dabble(scr_c, bin_c[WIDTH-1]);
        bin_a     <= {bin_a[WIDTH-2:0], 1'b0};
        bin_b     <= {bin_b[WIDTH-2:0], 1'b0};
        bin_c     <= {bin_c[WIDTH-2:0], 1'b0};
      end
      if (do_done) begin
        bcd_a <= scr_a;
        bcd_b <= scr_b;
        bcd_c <= scr_c;
      end
    end
  end

  assign bus.reg_a     = reg_a;
  assign bus.reg_b     = reg_b;
  assign bus.reg_c     = reg_c;
  assign bus.ovr       = ovr;
  assign bus.bcd_a     = bcd_a;
  assign bus.bcd_b     = bcd_b;
  assign bus.bcd_c     = bcd_c;
  assign bus.bcd_valid = bcd_valid;
  assign bus.busy      = busy_i;

endmodule

// File: tb/tb_alu_calc_core.sv
// ---------------------------------------------------------------------------
// tb_alu_calc_core
// Self-checking bench for alu_calc_core with WIDTH=8, DIGITS=3, DEBOUNCE=4.
// A table of operand/operation records is pressed through the keys; every
// register write pushes the expected BCD of A, B, C into a queue that is
// popped on each bcd_valid pulse. Hand-written sequences cover key glitches,
// key latency, presses while busy, simultaneous keys and reset mid-conversion.
// ---------------------------------------------------------------------------
module tb_alu_calc_core;

  localparam int WIDTH       = 8;
  localparam int DIGITS      = 3;
  localparam int DEBOUNCE    = 4;
  localparam int BUSY_CYCLES = WIDTH + 2;
  localparam int NVEC        = 15;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_ACC = 3'b111;

  typedef struct packed {
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] c;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] c;
    logic       ovr;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int errors = 0;
  int checks = 0;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[NVEC];

  logic [7:0] m_a;
  logic [7:0] m_b;
  logic [7:0] m_c;
  logic       m_ovr;

  int   busy_run;
  logic busy_prev;

  always #5 clk = ~clk;

  alu_calc_core_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  alu_calc_core #(
    .WIDTH   (WIDTH),
    .DIGITS  (DIGITS),
    .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Decimal reference encoding, independent of the shift-and-add engine.
  function automatic logic [11:0] to_bcd(input logic [7:0] v);
    int n;
    n = int'(v);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushExpected();
    sb.push_back({to_bcd(m_a), to_bcd(m_b), to_bcd(m_c)});
  endtask

  // Presses one key long enough to be accepted, releases it and waits for
  // the resulting conversion to finish.
  task automatic applyStimulus(input logic is_exec, input logic sel_b,
                               input logic [7:0] data, input logic [2:0] op,
                               input logic [7:0] exp_c, input logic exp_ovr);
    @(posedge clk);
    #1;
    bus.sw_data  = data;
    bus.sw_sel_b = sel_b;
    bus.sw_op    = op;
    if (is_exec) begin
      bus.key_exec_n = 1'b0;
      m_c   = exp_c;
      m_ovr = exp_ovr;
    end else begin
      bus.key_load_n = 1'b0;
      if (sel_b) m_b = data;
      else       m_a = data;
    end
    pushExpected();
    repeat (DEBOUNCE + 6) @(posedge clk);
    #1;
    bus.key_load_n = 1'b1;
    bus.key_exec_n = 1'b1;
    repeat (DEBOUNCE + BUSY_CYCLES + 10) @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer and busy-length monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run  = 0;
      busy_prev = 1'b0;
    end else begin
      if (bus.bcd_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL bcd_valid_unexpected: got pulse, expected none");
        end else begin
          mon_e = sb.pop_front();
          checkOutput("bcd_a", 32'(bus.bcd_a), 32'(mon_e.a));
          checkOutput("bcd_b", 32'(bus.bcd_b), 32'(mon_e.b));
          checkOutput("bcd_c", 32'(bus.bcd_c), 32'(mon_e.c));
        end
      end
      if (bus.busy) begin
        busy_run++;
      end else if (busy_prev) begin
        checkOutput("busy_len", 32'(busy_run), 32'(BUSY_CYCLES));
        checkOutput("valid_at_busy_fall", 32'(bus.bcd_valid), 32'd1);
        busy_run = 0;
      end
      busy_prev = bus.busy;
    end
  end

  initial begin
    #10000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{8'd200,  8'd100, OP_ADD, 8'd44,   1'b1};
    vecs[1]  = '{8'd100,  8'd200, OP_SUB, 8'd156,  1'b1};
    vecs[2]  = '{8'hF0,   8'h3C,  OP_AND, 8'h30,   1'b0};
    vecs[3]  = '{8'hF0,   8'h3C,  OP_OR,  8'hFC,   1'b0};
    vecs[4]  = '{8'hF0,   8'h3C,  OP_XOR, 8'hCC,   1'b0};
    vecs[5]  = '{8'hF0,   8'h3C,  OP_NOT, 8'h0F,   1'b0};
    vecs[6]  = '{8'h81,   8'h00,  OP_SHL, 8'h02,   1'b1};
    vecs[7]  = '{8'd5,    8'd0,   OP_AND, 8'd0,    1'b0};
    vecs[8]  = '{8'd5,    8'd0,   OP_ACC, 8'd5,    1'b0};
    vecs[9]  = '{8'd5,    8'd0,   OP_ACC, 8'd10,   1'b0};
    vecs[10] = '{8'd5,    8'd0,   OP_ACC, 8'd15,   1'b0};
    vecs[11] = '{8'd200,  8'd100, OP_SUB, 8'd100,  1'b0};
    vecs[12] = '{8'd255,  8'd1,   OP_ADD, 8'd0,    1'b1};
    vecs[13] = '{8'd250,  8'd0,   OP_ACC, 8'd250,  1'b0};
    vecs[14] = '{8'd10,   8'd0,   OP_ACC, 8'd4,    1'b1};

    bus.sw_data    = '0;
    bus.sw_sel_b   = 1'b0;
    bus.sw_op      = 3'b000;
    bus.key_load_n = 1'b1;
    bus.key_exec_n = 1'b1;
    m_a   = '0;
    m_b   = '0;
    m_c   = '0;
    m_ovr = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("rst_reg_a", 32'(bus.reg_a), 32'd0);
    checkOutput("rst_reg_b", 32'(bus.reg_b), 32'd0);
    checkOutput("rst_reg_c", 32'(bus.reg_c), 32'd0);
    checkOutput("rst_ovr", 32'(bus.ovr), 32'd0);
    checkOutput("rst_bcd_a", 32'(bus.bcd_a), 32'h000);
    checkOutput("rst_bcd_b", 32'(bus.bcd_b), 32'h000);
    checkOutput("rst_bcd_c", 32'(bus.bcd_c), 32'h000);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_valid", 32'(bus.bcd_valid), 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(1'b0, 1'b0, vecs[i].a, vecs[i].op, 8'd0, 1'b0);
      applyStimulus(1'b0, 1'b1, vecs[i].b, vecs[i].op, 8'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 8'd0, vecs[i].op, vecs[i].c, vecs[i].ovr);
      checkOutput($sformatf("vec%0d_c", i), 32'(bus.reg_c), 32'(vecs[i].c));
      checkOutput($sformatf("vec%0d_ovr", i), 32'(bus.ovr), 32'(vecs[i].ovr));
    end

    // Synchronised low for one cycle less than DEBOUNCE: no event.
    @(posedge clk);
    #1;
    bus.sw_data    = 8'h11;
    bus.sw_sel_b   = 1'b0;
    bus.key_load_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.key_load_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("glitch_reg_a", 32'(bus.reg_a), 32'(m_a));

    // Key held low for 10 cycles from edge t: write lands at edge t+7.
    @(posedge clk);
    #1;
    bus.sw_data    = 8'h5A;
    bus.sw_sel_b   = 1'b0;
    bus.key_load_n = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("latency_before", 32'(bus.reg_a), 32'(m_a));
    m_a = 8'h5A;
    pushExpected();
    @(posedge clk);
    #1;
    checkOutput("latency_at", 32'(bus.reg_a), 32'h5A);
    repeat (3) @(posedge clk);
    #1;
    bus.key_load_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;

    applyStimulus(1'b0, 1'b1, 8'd30, OP_ADD, 8'd0, 1'b0);

    // Execute starts a conversion; a load accepted while busy is dropped.
    @(posedge clk);
    #1;
    bus.sw_op      = OP_ADD;
    bus.key_exec_n = 1'b0;
    m_c   = 8'd120;
    m_ovr = 1'b0;
    pushExpected();
    repeat (3) @(posedge clk);
    #1;
    bus.sw_data    = 8'h77;
    bus.sw_sel_b   = 1'b0;
    bus.key_load_n = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    bus.key_load_n = 1'b1;
    bus.key_exec_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checkOutput("busy_drop_reg_a", 32'(bus.reg_a), 32'h5A);
    checkOutput("busy_drop_reg_c", 32'(bus.reg_c), 32'd120);
    checkOutput("busy_drop_ovr", 32'(bus.ovr), 32'd0);

    // Both keys accepted on the same cycle: only the load is performed.
    @(posedge clk);
    #1;
    bus.sw_data    = 8'h33;
    bus.sw_sel_b   = 1'b1;
    bus.sw_op      = OP_SUB;
    bus.key_load_n = 1'b0;
    bus.key_exec_n = 1'b0;
    m_b = 8'h33;
    pushExpected();
    repeat (10) @(posedge clk);
    #1;
    bus.key_load_n = 1'b1;
    bus.key_exec_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checkOutput("same_cycle_reg_b", 32'(bus.reg_b), 32'h33);
    checkOutput("same_cycle_reg_c", 32'(bus.reg_c), 32'd120);

    // Largest value converts to three full digits.
    applyStimulus(1'b0, 1'b0, 8'd255, OP_ADD, 8'd0, 1'b0);
    checkOutput("bcd_a_255", 32'(bus.bcd_a), 32'h255);

    // Reset asserted in the middle of SHIFT discards the conversion.
    @(posedge clk);
    #1;
    bus.sw_data    = 8'h42;
    bus.sw_sel_b   = 1'b0;
    bus.key_load_n = 1'b0;
    m_a = 8'h42;
    pushExpected();
    repeat (12) @(posedge clk);
    #1;
    checkOutput("busy_before_reset", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_bcd_a", 32'(bus.bcd_a), 32'h000);
    checkOutput("reset_reg_a", 32'(bus.reg_a), 32'd0);
    checkOutput("reset_reg_c", 32'(bus.reg_c), 32'd0);
    checkOutput("reset_valid", 32'(bus.bcd_valid), 32'd0);
    sb.delete();
    m_a   = '0;
    m_b   = '0;
    m_c   = '0;
    m_ovr = 1'b0;
    bus.key_load_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checkOutput("post_reset_bcd_a", 32'(bus.bcd_a), 32'h000);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_calc_core.md
# alu_calc_core

Clocked, parametrised successor to the board-level 4-bit ALU top. It holds operand registers A and B and result register C. Two debounced push-keys drive it: one loads A or B from the switches, one executes an ALU operation into C. A, B and C are re-encoded to packed BCD for the seven-segment decoders by a multi-cycle serial double-dabble engine. It sits between the board switches/keys and the existing seven-segment decoder instances.

## Interface
- WIDTH, 8, operand/result width in bits (≥2).
- DIGITS, 3, BCD digits per value; must satisfy 10^DIGITS > 2^WIDTH−1.
- DEBOUNCE, 250000, cycles a synchronised key level must stay stable before it is accepted.

Clocking and reset: one clock; reset is asynchronous and active-low.

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sw_data  in  WIDTH  operand value to load
- sw_sel_b  in  1  load target: 0 = A, 1 = B
- sw_op  in  3  ALU operation code
- key_load_n  in  1  load key, active-low, asynchronous to clk
- key_exec_n  in  1  execute key, active-low, asynchronous to clk
- reg_a, reg_b, reg_c  out  WIDTH  register contents
- ovr  out  1  overflow flag of the last execute
- bcd_a, bcd_b, bcd_c  out  4*DIGITS  packed BCD of A, B, C; digit 0 in [3:0]
- bcd_valid  out  1  one-cycle pulse when BCD outputs update
- busy  out  1  conversion in progress

## Operation
- Key path, per key:
  - 2-flop synchroniser feeds a debounce counter.
  - The counter resets on any change of the synchronised level.
  - When the level has been stable for DEBOUNCE cycles, the debounced level takes it.
  - A high→low debounced transition produces a one-cycle press event.
  - Release produces no event.
- Load event: sw_data is written to A (sw_sel_b = 0) or to B (sw_sel_b = 1).
- Execute event:
  - C and ovr are written from the current A, B, C.
  - All results are truncated to WIDTH bits.
- Operation codes (sw_op):
  - 000 ADD A+B; ovr = carry out.
  - 001 SUB A−B; ovr = borrow (A<B).
  - 010 AND; ovr = 0.
  - 011 OR; ovr = 0.
  - 100 XOR; ovr = 0.
  - 101 NOT A; ovr = 0.
  - 110 SHL A by 1; ovr = A[WIDTH−1].
  - 111 ACC C+A; ovr = carry out.
- Overflow is unsigned only.
- ovr holds its value until the next execute.
- Conversion FSM:
  - States: IDLE, LOAD, SHIFT, DONE.
  - IDLE→LOAD on any register write.
  - LOAD snapshots A, B, C into three shift engines and clears the BCD scratch.
  - SHIFT runs exactly WIDTH cycles of add-3-then-shift on all three engines in parallel.
  - DONE writes bcd_a/b/c atomically, pulses bcd_valid, and returns to IDLE.
- Press events arriving while busy = 1 are dropped, not queued.
- A load event and an execute event in the same cycle: load wins, execute is dropped.
- sw_* inputs are sampled only on the event cycle; they are not synchronised.

## Timing
- Reset values:
  - reg_a, reg_b, reg_c = 0; ovr = 0.
  - bcd_a, bcd_b, bcd_c = 0 (this is the correct BCD for 0).
  - bcd_valid = 0; busy = 0.
  - FSM in IDLE; debounced key levels = released (1); debounce counters = 0.
- Key latency: with the key held low from clock edge t, the register write occurs at edge t+DEBOUNCE+3.
  - 2 edges for the synchroniser.
  - DEBOUNCE edges for the counter.
  - 1 edge for the event/write.
- A synchronised-low pulse shorter than DEBOUNCE cycles never produces an event.
- Conversion:
  - busy rises at the edge after the register write.
  - busy stays high for WIDTH+2 cycles (LOAD + WIDTH × SHIFT + DONE).
  - BCD outputs and the bcd_valid pulse occur on the DONE→IDLE edge, the same edge at which busy falls.
- Execute: C reflects operands as they were before the write edge. ACC uses the old C.
- rst_n low mid-conversion or mid-debounce: all state returns immediately to its reset value; partial BCD is discarded.

## Test plan
Bench parameters: WIDTH=8, DIGITS=3, DEBOUNCE=4.

- Release rst_n after 3 cycles -> all registers 0, bcd_a/b/c = 0x000, busy 0, bcd_valid never pulses.
- Load A=200 and B=100, then execute ADD -> reg_c = 44, ovr = 1, bcd_c = 0x044. busy lasts exactly 10 cycles; bcd_valid pulses once per write.
- Execute SUB with A=100, B=200 -> C = 156, ovr = 1. Then A=5, C=0, three ACC executes -> C = 15, ovr = 0. Then A=0x81, SHL -> C = 0x02, ovr = 1.
- key_load_n glitches low for 3 synchronised cycles -> no register change. Held low for 10 cycles -> write at edge t+7.
- Load pressed while busy -> dropped, A unchanged. Load and execute debounced in the same cycle -> only the load takes effect.
- Load A=255 -> bcd_a = 0x255. Assert rst_n mid-SHIFT -> busy 0 immediately, bcd_a = 0x000, no bcd_valid pulse.
